// File: rtl/fetch_buffer_pkg.sv
// Shared widths, defaults and the fetch-queue entry type for the fetch buffer.
package fetch_buffer_pkg;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DEF_DEPTH = 4;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC = '0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Instruction-memory, decode and redirect signals of the fetch buffer.
interface fetch_buffer_if;
  import fetch_buffer_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               out_ready;

  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_rvalid, imem_rdata, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_rvalid, imem_rdata, out_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular queue of fetched {instr, pc} entries with a synchronous flush.
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full, do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      // Pointers only need to be equal; snapping read to write avoids touching storage.
      cnt_d = '0;
      rd_d  = wr_q;
    end else begin
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full && !pop_i && !flush_i));

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch front end: credit-limited PC sequencing, redirect/squash handling,
// and a small in-order queue feeding decode.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned       DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic          clk,
  input  logic          resetn,
  fetch_buffer_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic              squash_q, squash_d;

  logic [CW-1:0]     count;
  fetch_entry_t      head, push_entry;
  logic              credit_ok, issue, push, pop, flush, valid;

  // Outstanding request counts against capacity so a response always has a slot.
  assign credit_ok = ({1'b0, count} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(DEPTH);
  assign flush     = bus.redirect_valid;
  assign issue     = credit_ok && !bus.redirect_valid;
  assign valid     = (count != '0);
  assign pop       = valid && bus.out_ready;
  assign push      = bus.imem_rvalid && inflight_q && !squash_q && !flush;

  assign push_entry = '{instr: bus.imem_rdata, pc: req_pc_q};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    squash_d   = squash_q;
    if (bus.imem_rvalid) begin
      inflight_d = 1'b0;
      squash_d   = 1'b0;
    end
    if (issue) begin
      fetch_pc_d = pc_inc(fetch_pc_q);
      req_pc_d   = fetch_pc_q;
      inflight_d = 1'b1;
    end
    if (flush) begin
      fetch_pc_d = bus.redirect_pc;
      // A response landing this cycle is already dropped; only a later one needs marking.
      if (inflight_q && !bus.imem_rvalid) squash_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (resetn),
    .flush_i    (flush),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count)
  );

  assign bus.imem_req  = issue && resetn;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = valid;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed scenarios for fetch_buffer with a queue-based scoreboard on the decode port.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  fetch_buffer_if bus ();

  fetch_buffer #(
    .DEPTH   (4),
    .RESET_PC(16'h0000)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  fetch_entry_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic exp_push(input logic [15:0] pc);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = pc + 16'h1000;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: one-cycle response, data = 0x1000 + address.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.imem_rvalid <= 1'b0;
      bus.imem_rdata  <= '0;
    end else begin
      bus.imem_rvalid <= bus.imem_req;
      bus.imem_rdata  <= bus.imem_addr + 16'h1000;
    end
  end

  always @(negedge clk) begin : monitor
    fetch_entry_t e;
    if (resetn && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected_pc", 32'(bus.out_pc), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", 32'(bus.out_pc), 32'(e.pc));
        check("pop_instr", 32'(bus.out_instr), 32'(e.instr));
      end
    end
  end

  initial begin
    int nreq;
    int lat;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    repeat (2) tick();
    @(negedge clk);
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pc", 32'(bus.out_pc), 32'd0);
    check("rst_out_instr", 32'(bus.out_instr), 32'd0);

    for (int i = 0; i < 25; i++) exp_push(16'(i));
    for (int i = 0; i < 6; i++) exp_push(16'(16'h40 + i));
    exp_push(16'hFFFE);
    exp_push(16'hFFFF);
    exp_push(16'h0000);
    exp_push(16'h0001);

    // Stall decode for 10 cycles right after reset release.
    tick();
    resetn = 1'b1;
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) check("first_req_addr", 32'(bus.imem_addr), 32'd0);
      if (bus.imem_req) nreq++;
      if (c == 9) begin
        check("stall_full_valid", 32'(bus.out_valid), 32'd1);
        check("stall_head_pc", 32'(bus.out_pc), 32'd0);
        check("stall_req_off", 32'(bus.imem_req), 32'd0);
      end
      tick();
    end
    check("stall_req_count", 32'(nreq), 32'd4);

    // Cycle 10: stream 20 entries, then refill to full.
    bus.out_ready = 1'b1;
    repeat (20) tick();
    bus.out_ready = 1'b0;
    repeat (4) tick();
    // Cycle 34..37: single pops, including pop + response at maximum occupancy.
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0; tick();
    bus.out_ready = 1'b1; tick();
    bus.out_ready = 1'b0; repeat (3) tick();
    // Cycle 40: drain two, redirect on cycle 42 with a response in flight.
    bus.out_ready = 1'b1;
    repeat (2) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h0040;
    @(negedge clk);
    check("redir_req_low", 32'(bus.imem_req), 32'd0);
    check("redir_valid_preflush", 32'(bus.out_valid), 32'd1);
    check("redir_head_pc", 32'(bus.out_pc), 32'd24);
    tick();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("post_redir_req", 32'(bus.imem_req), 32'd1);
    check("post_redir_addr", 32'(bus.imem_addr), 32'h40);
    check("post_redir_empty", 32'(bus.out_valid), 32'd0);

    // Cycle 50/51: back-to-back redirects, the second must win.
    repeat (7) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 16'h1234;
    tick();
    bus.redirect_pc    = 16'hFFFE;
    @(negedge clk);
    check("b2b_req_low", 32'(bus.imem_req), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("b2b_last_wins", 32'(bus.imem_addr), 32'hFFFE);
    check("b2b_req_resume", 32'(bus.imem_req), 32'd1);
    repeat (2) tick();
    @(negedge clk);
    check("pc_wrap", 32'(bus.imem_addr), 32'h0000);

    // Cycle 58: stop decode, assert reset with three entries queued at cycle 60.
    repeat (4) tick();
    bus.out_ready = 1'b0;
    repeat (2) tick();
    check("scoreboard_drained_1", 32'(exp_q.size()), 32'd0);
    check("queued_before_reset", 32'(bus.out_valid), 32'd1);
    resetn = 1'b0;
    #2;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_imem_req", 32'(bus.imem_req), 32'd0);
    check("midrst_out_pc", 32'(bus.out_pc), 32'd0);
    check("midrst_out_instr", 32'(bus.out_instr), 32'd0);

    for (int i = 0; i < 4; i++) exp_push(16'(i));
    repeat (2) tick();
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    lat = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check("restart_req", 32'(bus.imem_req), 32'd1);
        check("restart_addr", 32'(bus.imem_addr), 32'd0);
      end
      if (bus.out_valid) begin
        lat = c;
        break;
      end
      tick();
    end
    check("fetch_latency", 32'(lat), 32'd2);
    repeat (4) tick();
    bus.out_ready = 1'b0;
    repeat (2) tick();
    check("scoreboard_drained_2", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter INSTR_W, 16, instruction width in bits.
REQ-002 Parameter ADDR_W, 16, PC and instruction-memory word-address width.
REQ-003 Parameter DEPTH, 4, queue entries; power of two, at least 2.
REQ-004 Parameter RESET_PC, 0, first fetch address after reset.
REQ-005 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 imem_req  out  1  fetch request to instruction memory this cycle.
REQ-008 imem_addr  out  ADDR_W  word address of the request.
REQ-009 imem_rvalid  in  1  response valid; asserted exactly one cycle after each request.
REQ-010 imem_rdata  in  INSTR_W  instruction returned with imem_rvalid.
REQ-011 out_valid  out  1  head entry available to decode.
REQ-012 out_instr  out  INSTR_W  head instruction.
REQ-013 out_pc  out  ADDR_W  PC of the head instruction.
REQ-014 out_ready  in  1  decode accepts the head; a pop occurs when out_valid and out_ready are both high.
REQ-015 redirect_valid  in  1  branch or jump redirect; flushes the queue.
REQ-016 redirect_pc  in  ADDR_W  new fetch address.

Function
REQ-017 fetch_pc register SHALL drive imem_addr; it SHALL increment by 1 on every issued request and wrap modulo 2^ADDR_W.
REQ-018 imem_req SHALL be high iff (count + inflight) < DEPTH and redirect_valid is low; inflight is 0 or 1.
REQ-019 An imem_rvalid response SHALL be pushed at the tail as {imem_rdata, pc_of_request} unless marked squashed.
REQ-020 out_valid SHALL equal (count != 0); out_instr and out_pc SHALL be driven from head registers, not from imem_rdata (no bypass).
REQ-021 Fetch latency: with out_ready high and no redirect, a request issued in cycle N SHALL appear on out_valid in cycle N+2.
REQ-022 Throughput: the queue SHALL sustain one push and one pop per cycle indefinitely.
REQ-023 Push and pop in the same cycle SHALL leave count unchanged, including at count == DEPTH.
REQ-024 The credit rule in REQ-018 SHALL guarantee no push when full; an overflow is a design error and SHALL be flagged by an assertion.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits and wrap naturally; count SHALL be log2(DEPTH)+1 bits.
REQ-026 On redirect_valid, the next edge SHALL set count=0, equalise the pointers, and load fetch_pc with redirect_pc.
REQ-027 A redirect SHALL mark any inflight request as squashed; its response in the next cycle SHALL be discarded.
REQ-028 During a redirect cycle, out_valid SHALL still reflect the pre-flush queue.
REQ-029 A pop coinciding with a redirect SHALL be honoured; the push is dropped.
REQ-030 imem_req SHALL resume in the cycle after redirect, from redirect_pc.
REQ-031 Back-to-back redirects SHALL each reload fetch_pc; the last one wins.

Reset
REQ-032 While resetn is low: fetch_pc=RESET_PC, count=0, pointers=0, inflight=0, squash=0, imem_req=0, out_valid=0; out_instr and out_pc SHALL be 0.
REQ-033 The first imem_req SHALL assert in the first cycle after resetn deasserts.
REQ-034 Reset asserted mid-operation SHALL drop queued and inflight entries immediately, with no residual output.

Structure
REQ-035 A shared package SHALL hold INSTR_W, ADDR_W, the default DEPTH and RESET_PC, and a fetch-entry struct {instr, pc}.
REQ-036 Queue storage and pointers SHALL be one sub-module, fetch_fifo, with a synchronous flush input; fetch_buffer SHALL own the PC, credit and squash logic.

Verification
REQ-037 Reset release, RESET_PC=0, memory returns 16'h1000+addr, out_ready=1 -> out_pc 0,1,2,3 on consecutive cycles from cycle 2, with instr 16'h1000..16'h1003.
REQ-038 out_ready=0 for 10 cycles, DEPTH=4 -> imem_req drops after 4 requests, count holds at 4; out_ready=1 then yields pcs 0..3 with no loss or duplication.
REQ-039 redirect_valid with redirect_pc=16'h0040 while one request is inflight -> that response is discarded; the next out_pc is 16'h0040.
REQ-040 Full queue with pop and rvalid in the same cycle -> count stays 4 and order is preserved.
REQ-041 fetch_pc=16'hFFFF -> the next request is 16'h0000.
REQ-042 resetn pulsed low with 3 entries queued -> out_valid falls immediately; after release, fetch restarts at RESET_PC.
